// File: rtl/pdm_rx_frontend.sv
// PDM receive front end: divided mic clock, dual-edge capture per pin,
// frame FIFO, and a masked channel serialiser with valid/ready output.
module pdm_rx_frontend #(
  parameter int NUM_PINS   = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int NUM_CH    = 2 * NUM_PINS,
  localparam int CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_clkdiv_i,
  input  logic [NUM_CH-1:0]    cfg_ch_mask_i,
  input  logic                 cfg_clr_ovf_i,
  output logic                 pdm_clk_o,
  input  logic [NUM_PINS-1:0]  pdm_data_i,
  output logic                 bit_o,
  output logic [CH_W-1:0]      bit_ch_o,
  output logic                 bit_last_o,
  output logic                 bit_valid_o,
  input  logic                 bit_ready_i,
  output logic                 overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic                 tick, rise, fall;

  logic [NUM_PINS-1:0]  cap_q, cap_d;
  logic                 hi_seen_q, hi_seen_d;
  logic [NUM_CH-1:0]    frame_in;
  logic                 push, push_ok, pop, full, empty;

  logic [NUM_CH-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NUM_CH-1:0]    rd_frame;
  logic                 ovf_q, ovf_d;

  logic [0:0]           state_q, state_d;
  logic [NUM_CH-1:0]    frame_q, frame_d, mask_q, mask_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 has_above;

  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = CH_W'(i);
    end
    return r;
  endfunction

  // A terminal count at or above D also wraps, so lowering D mid-run cannot stall the divider.
  assign tick = cfg_en_i && (cnt_q >= cfg_clkdiv_i);
  assign rise = tick && !pdm_clk_q;
  assign fall = tick && pdm_clk_q;

  always_comb begin
    cnt_d     = cnt_q;
    pdm_clk_d = pdm_clk_q;
    if (!cfg_en_i) begin
      cnt_d     = '0;
      pdm_clk_d = 1'b0;
    end else if (tick) begin
      cnt_d     = '0;
      pdm_clk_d = ~pdm_clk_q;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Even channels are held from the high phase; odd channels join the frame at the rise.
  always_comb begin
    cap_d     = cap_q;
    hi_seen_d = hi_seen_q;
    if (!cfg_en_i) begin
      cap_d     = '0;
      hi_seen_d = 1'b0;
    end else if (fall) begin
      cap_d     = pdm_data_i;
      hi_seen_d = 1'b1;
    end
  end

  always_comb begin
    frame_in = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      frame_in[2*p]   = cap_q[p];
      frame_in[2*p+1] = pdm_data_i[p];
    end
  end

  assign push     = rise && hi_seen_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok  = push && !full;
  assign pop      = cfg_en_i && (state_q == ST_IDLE) && !empty;
  assign rd_frame = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PW'(push_ok);
    rptr_d = rptr_q + PW'(pop);
    if (!cfg_en_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (cfg_clr_ovf_i) ovf_d = 1'b0;
    if (push && full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= frame_in;
  end

  always_comb begin
    has_above = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask_q[i] && i > int'(ch_q)) has_above = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
      frame_d = '0;
      mask_d  = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An all-zero mask still pops, discarding the frame.
          if (!empty && cfg_ch_mask_i != '0) begin
            frame_d = rd_frame;
            mask_d  = cfg_ch_mask_i;
            ch_d    = first_set(cfg_ch_mask_i, 0);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_ready_i) begin
            if (!has_above) state_d = ST_IDLE;
            else            ch_d    = first_set(mask_q, int'(ch_q) + 1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
      cap_q     <= '0;
      hi_seen_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
      cap_q     <= cap_d;
      hi_seen_q <= hi_seen_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      frame_q   <= frame_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
    end
  end

  assign pdm_clk_o   = pdm_clk_q;
  assign bit_valid_o = (state_q == ST_SHIFT);
  assign bit_o       = bit_valid_o & frame_q[ch_q];
  assign bit_ch_o    = ch_q;
  assign bit_last_o  = bit_valid_o & ~has_above;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_pdm_rx_frontend.sv
// Directed bench for pdm_rx_frontend: clock timing, ordering, masking,
// backpressure with overflow, and disable mid-frame.
module tb_pdm_rx_frontend;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_en_i;
  logic [7:0] cfg_clkdiv_i;
  logic [3:0] cfg_ch_mask_i;
  logic       cfg_clr_ovf_i;
  logic       pdm_clk_o;
  logic [1:0] pdm_data_i = 2'b00;
  logic       bit_o;
  logic [1:0] bit_ch_o;
  logic       bit_last_o;
  logic       bit_valid_o;
  logic       bit_ready_i;
  logic       overflow_o;

  pdm_rx_frontend #(.NUM_PINS(2), .DIV_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_clkdiv_i(cfg_clkdiv_i),
    .cfg_ch_mask_i(cfg_ch_mask_i), .cfg_clr_ovf_i(cfg_clr_ovf_i), .pdm_clk_o(pdm_clk_o),
    .pdm_data_i(pdm_data_i), .bit_o(bit_o), .bit_ch_o(bit_ch_o), .bit_last_o(bit_last_o),
    .bit_valid_o(bit_valid_o), .bit_ready_i(bit_ready_i), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Pin pattern per phase: mode 0 fixed, mode 1 varies per frame, mode 2 inverted fixed.
  int mode = 0;
  function automatic logic [1:0] pat(input int m, input int f, input bit hi);
    logic [3:0] v;
    v = 4'(f + 9);
    case (m)
      0:       return hi ? 2'b01 : 2'b10;
      1:       return hi ? v[1:0] : v[3:2];
      default: return hi ? 2'b10 : 2'b01;
    endcase
  endfunction

  function automatic logic frame_bit(input int m, input int f, input int ch);
    logic [1:0] p;
    p = pat(m, f, (ch % 2) == 0);
    return p[ch/2];
  endfunction

  function automatic logic [3:0] ent(input int ch, input logic b, input logic l);
    return {2'(ch), b, l};
  endfunction

  // Data driver: new data at the start of each PDM phase; fidx counts frames since enable.
  int   fidx = 0;
  bit   started = 0;
  logic prev_clk = 1'b0;
  always @(posedge clk_i) begin
    #2;
    if (!cfg_en_i) begin
      fidx    = 0;
      started = 0;
    end else if (pdm_clk_o && !prev_clk) begin
      if (started) fidx++;
      started    = 1;
      pdm_data_i = pat(mode, fidx, 1'b1);
    end else if (!pdm_clk_o && prev_clk) begin
      pdm_data_i = pat(mode, fidx, 1'b0);
    end
    prev_clk = pdm_clk_o;
  end

  logic [3:0] hs_q[$];
  always @(negedge clk_i) begin
    if (!rst_i && bit_valid_o && bit_ready_i) hs_q.push_back({bit_ch_o, bit_o, bit_last_o});
  end

  task automatic restart();
    cfg_en_i = 1'b0;
    step(2);
    hs_q.delete();
  endtask

  initial begin
    int n, bad, viol, rises, f, ch;
    logic pc, hold_bit;
    logic [1:0] hold_ch;

    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_clkdiv_i = 8'd3; cfg_ch_mask_i = 4'hF;
    cfg_clr_ovf_i = 1'b0; bit_ready_i = 1'b1;
    step(3);
    chk("reset_outs", {pdm_clk_o, bit_o, bit_ch_o, bit_last_o, bit_valid_o, overflow_o}, 0);
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if ({pdm_clk_o, bit_o, bit_ch_o, bit_last_o, bit_valid_o, overflow_o} !== 7'd0) bad++;
    end
    chk("idle_outs_nonzero", bad, 0);

    // clock timing, latency and full-mask ordering
    hs_q.delete(); mode = 0; cfg_en_i = 1'b1;
    n = 0; while (!pdm_clk_o && n < 50) begin step(1); n++; end
    chk("first_rise_cycles", n, 4);
    n = 0; while (pdm_clk_o && n < 50) begin step(1); n++; end
    chk("high_len", n, 4);
    n = 0; while (!pdm_clk_o && n < 50) begin step(1); n++; end
    chk("low_len", n, 4);
    chk("lat_valid_at_rise", bit_valid_o, 0);
    step(1);
    chk("lat_valid_next", bit_valid_o, 1);
    chk("lat_first_ch", bit_ch_o, 0);
    step(40);
    for (int i = 0; i < 12; i++) begin
      ch = i % 4;
      chk($sformatf("order_%0d", i), hs_q[i], ent(ch, frame_bit(0, 0, ch), ch == 3));
    end

    // mask 0101
    restart(); cfg_ch_mask_i = 4'b0101; cfg_en_i = 1'b1;
    step(50);
    for (int i = 0; i < 4; i++) begin
      ch = (i % 2) * 2;
      chk($sformatf("mask5_%0d", i), hs_q[i], ent(ch, frame_bit(0, 0, ch), ch == 2));
    end

    // mask 0
    restart(); cfg_ch_mask_i = 4'b0000; cfg_en_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (bit_valid_o) bad++;
    end
    chk("mask0_valid_cycles", bad, 0);
    chk("mask0_ovf", overflow_o, 0);

    // backpressure and overflow
    restart(); cfg_ch_mask_i = 4'hF; mode = 1; bit_ready_i = 1'b0; cfg_en_i = 1'b1;
    rises = 0; pc = 1'b0; n = 0;
    while (!bit_valid_o && n < 100) begin
      step(1); n++;
      if (pdm_clk_o && !pc) rises++;
      pc = pdm_clk_o;
    end
    chk("bp_valid_seen", bit_valid_o, 1);
    hold_ch = bit_ch_o; hold_bit = bit_o;
    chk("bp_hold_ch", hold_ch, 0);
    chk("bp_hold_bit", hold_bit, frame_bit(1, 0, 0));
    viol = 0; n = 0;
    while (!overflow_o && n < 200) begin
      step(1); n++;
      if (pdm_clk_o && !pc) rises++;
      pc = pdm_clk_o;
      if (bit_valid_o !== 1'b1 || bit_ch_o !== hold_ch || bit_o !== hold_bit) viol++;
    end
    chk("bp_stable_viol", viol, 0);
    chk("ovf_at_rise", rises, 7);
    bit_ready_i = 1'b1;
    step(90);
    for (int i = 0; i < 24; i++) begin
      f = i / 4; ch = i % 4;
      if (f == 5) f = 6;
      chk($sformatf("bp_drain_%0d", i), hs_q[i], ent(ch, frame_bit(1, f, ch), ch == 3));
    end
    chk("ovf_sticky", overflow_o, 1);
    cfg_clr_ovf_i = 1'b1; step(1); cfg_clr_ovf_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);

    // disable mid-frame, then re-enable with a new pattern
    restart(); mode = 0; cfg_en_i = 1'b1;
    n = 0;
    while (!(bit_valid_o && bit_ch_o == 2'd1) && n < 100) begin step(1); n++; end
    chk("dis_on_ch1", {bit_valid_o, bit_ch_o}, 3'b101);
    chk("dis_pre_clk", pdm_clk_o, 1);
    cfg_en_i = 1'b0;
    step(1);
    chk("dis_valid", bit_valid_o, 0);
    chk("dis_pdmclk", pdm_clk_o, 0);
    step(2);
    hs_q.delete(); mode = 2; cfg_en_i = 1'b1;
    step(40);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reen_%0d", i), hs_q[i], ent(i, frame_bit(2, 0, i), i == 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
